// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 64x32 scan controller.
package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY
    } scan_state_e;

    localparam int COLS_DEF  = 64;
    localparam int ROWS_DEF  = 16;
    localparam int DWELL_DEF = 256;

    localparam int COL_W     = $clog2(COLS_DEF);
    localparam int ROW_W     = $clog2(ROWS_DEF);
    localparam int FB_ADDR_W = 1 + ROW_W + COL_W;

    // fb_data = {R0,G0,B0,R1,G1,B1}
    localparam int PIX_W  = 6;
    localparam int PIX_R0 = 5;
    localparam int PIX_G0 = 4;
    localparam int PIX_B0 = 3;
    localparam int PIX_R1 = 2;
    localparam int PIX_G1 = 1;
    localparam int PIX_B1 = 0;

endpackage

// File: rtl/hub75_shift_seq.sv
// Shift phase of one row: column reads, RGB pixel registers and the panel shift clock.
module hub75_shift_seq
    import hub75_pkg::*;
#(
    parameter int COLS = COLS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    input  logic [PIX_W-1:0] fb_data,
    output logic             rd_en,
    output logic [COL_W-1:0] col,
    output logic [PIX_W-1:0] rgb,
    output logic             sclk
);

    localparam int LAST  = 2 * COLS + 1;
    localparam int CNT_W = $clog2(2 * COLS + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             sclk_q, sclk_d;
    logic [PIX_W-1:0] rgb_q;
    logic             load;

    assign done  = active_q && (cnt_q == CNT_W'(LAST));
    assign rd_en = active_q && !cnt_q[0] && (cnt_q < CNT_W'(2 * COLS));
    assign col   = cnt_q[COL_W:1];
    // Read data for column c is on fb_data during the odd count 2c+1.
    assign load  = active_q && cnt_q[0] && (cnt_q < CNT_W'(2 * COLS));

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (done) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Registered so the panel clock is glitch-free; high on odd counts from 3.
        sclk_d = active_d && cnt_d[0] && (cnt_d >= CNT_W'(3));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            rgb_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            sclk_q   <= sclk_d;
            if (load) rgb_q <= fb_data;
        end
    end

    assign rgb  = rgb_q;
    assign sclk = sclk_q;

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row scanner with frame-boundary bank swaps.
// Optional macro SCAN_DIM_EN: per-frame global dimming of the DISPLAY on-time.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 fb_rd_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [PIX_W-1:0]     fb_data,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 front_bank,
    output logic                 frame_done,
    input  logic [7:0]           brightness,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    output logic                 D,
    output logic                 R0,
    output logic                 G0,
    output logic                 B0,
    output logic                 R1,
    output logic                 G1,
    output logic                 B1,
    output logic                 SCLK,
    output logic                 LAT,
    output logic                 OE
);

    localparam int DWELL_W = $clog2(DWELL);

    scan_state_e        state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ROW_W-1:0]   addr_q;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               bank_q, bank_d;
    logic               frame_done_q, frame_done_d;
    logic               swap_ack_q, swap_ack_d;
    logic               lat_q, oe_q;
    logic               start, shift_done, disp_on;
    logic [COL_W-1:0]   col;
    logic [PIX_W-1:0]   rgb;
    logic               sclk;

`ifdef SCAN_DIM_EN
    logic [7:0] brightness_q;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
`endif

    hub75_shift_seq #(
        .COLS (COLS)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .done    (shift_done),
        .fb_data (fb_data),
        .rd_en   (fb_rd_en),
        .col     (col),
        .rgb     (rgb),
        .sclk    (sclk)
    );

    always_comb begin
        // NOTE: every _d gets its current value first, so no branch can infer a latch.
        state_d      = state_q;
        row_d        = row_q;
        dwell_d      = dwell_q;
        bank_d       = bank_q;
        frame_done_d = 1'b0;
        swap_ack_d   = 1'b0;
        unique case (state_q)
            IDLE:    if (run) state_d = SHIFT;
            SHIFT:   if (shift_done) state_d = LATCH;
            LATCH: begin
                state_d = DISPLAY;
                dwell_d = '0;
            end
            DISPLAY: begin
                if (dwell_q == DWELL_W'(DWELL - 1)) begin
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        frame_done_d = 1'b1;
                        row_d        = '0;
                        if (swap_req) begin
                            bank_d     = ~bank_q;
                            swap_ack_d = 1'b1;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                    // A stop mid-frame abandons the remaining rows.
                    if (run) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                        row_d   = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        start = (state_q != SHIFT) && (state_d == SHIFT);
`ifdef SCAN_DIM_EN
        disp_on = (state_d == DISPLAY) && (32'(dwell_d) < 32'(brightness_q));
`else
        disp_on = (state_d == DISPLAY);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            addr_q       <= '0;
            dwell_q      <= '0;
            bank_q       <= 1'b0;
            frame_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            lat_q        <= 1'b0;
            oe_q         <= 1'b1;
`ifdef SCAN_DIM_EN
            brightness_q <= '0;
`endif
        end else begin
            // NOTE: state registers use <= only; blocking here would make the result depend on process order.
            state_q      <= state_d;
            row_q        <= row_d;
            dwell_q      <= dwell_d;
            bank_q       <= bank_d;
            frame_done_q <= frame_done_d;
            swap_ack_q   <= swap_ack_d;
            lat_q        <= (state_d == LATCH);
            oe_q         <= ~disp_on;
            if (start) addr_q <= row_d;
`ifdef SCAN_DIM_EN
            if (start && row_d == '0) brightness_q <= brightness;
`endif
        end
    end

    assign fb_addr    = {bank_q, row_q, col};
    assign front_bank = bank_q;
    assign frame_done = frame_done_q;
    assign swap_ack   = swap_ack_q;
    assign {D, C, B, A} = addr_q;
    assign R0   = rgb[PIX_R0];
    assign G0   = rgb[PIX_G0];
    assign B0   = rgb[PIX_B0];
    assign R1   = rgb[PIX_R1];
    assign G1   = rgb[PIX_G1];
    assign B1   = rgb[PIX_B1];
    assign SCLK = sclk;
    assign LAT  = lat_q;
    assign OE   = oe_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: random frame memory, cycle-accurate row-phase reference model.
module tb_hub75_scan_ctrl;

    localparam int COLS      = 64;
    localparam int ROWS      = 16;
    localparam int DWELL     = 256;
    localparam int SHIFT_LEN = 2 * COLS + 2;
    localparam int ROW_PER   = SHIFT_LEN + 1 + DWELL;
    localparam int FRAME_PER = ROWS * ROW_PER;
    localparam int BANK_SZ   = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        swap_req = 1'b0;
    logic [7:0]  brightness = 8'd64;
    logic [5:0]  fb_data = '0;
    logic        fb_rd_en, swap_ack, front_bank, frame_done;
    logic [10:0] fb_addr;
    logic        A, B, C, D, R0, G0, B0, R1, G1, B1, SCLK, LAT, OE;

    hub75_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .fb_rd_en   (fb_rd_en),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .front_bank (front_bank),
        .frame_done (frame_done),
        .brightness (brightness),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .R0         (R0),
        .G0         (G0),
        .B0         (B0),
        .R1         (R1),
        .G1         (G1),
        .B1         (B1),
        .SCLK       (SCLK),
        .LAT        (LAT),
        .OE         (OE)
    );

    always #5 clk = ~clk;

    logic [5:0] mem [2048];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: position m_p within the 387-cycle row period.
    bit   m_active = 0;
    int   m_p = 0, m_row = 0, m_bank = 0, m_bright = 0, m_abcd = 0;
    bit   m_fd = 0, m_ack = 0;
    logic [5:0] m_rgb = '0;

    int   sclk_rises = 0;
    logic sclk_prev = 1'b0;
    int   fd_last = 0;
    int   fd_seen = 0, ack_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit r_rst, input bit r_run, input bit r_swap, input int r_br);
        if (r_rst) begin
            m_active = 0; m_p = 0; m_row = 0; m_bank = 0; m_bright = 0;
            m_abcd = 0; m_fd = 0; m_ack = 0; m_rgb = '0;
            return;
        end
        m_fd  = 0;
        m_ack = 0;
        if (!m_active) begin
            if (r_run) begin
                m_active = 1;
                m_p = 0;
            end
        end else if (m_p == ROW_PER - 1) begin
            if (m_row == ROWS - 1) begin
                m_fd = 1;
                if (r_swap) begin
                    m_bank ^= 1;
                    m_ack = 1;
                end
            end
            m_row = (m_row + 1) % ROWS;
            if (r_run) m_p = 0;
            else begin
                m_active = 0;
                m_row = 0;
            end
        end else begin
            m_p++;
        end
        if (m_active && m_p == 0) begin
            m_abcd = m_row;
            if (m_row == 0) m_bright = r_br;
        end
        if (m_active && m_p % 2 == 0 && m_p >= 2 && m_p <= 2 * COLS)
            m_rgb = mem[m_bank * BANK_SZ + m_row * COLS + (m_p - 2) / 2];
    endtask

    task automatic compare();
        bit e_disp, e_rd;
        e_disp = m_active && m_p >= SHIFT_LEN + 1;
`ifdef SCAN_DIM_EN
        if (e_disp && (m_p - SHIFT_LEN - 1) >= m_bright) e_disp = 0;
`endif
        e_rd = m_active && m_p % 2 == 0 && m_p < 2 * COLS;
        check("OE", OE, !e_disp);
        check("LAT", LAT, m_active && m_p == SHIFT_LEN);
        check("SCLK", SCLK, m_active && m_p % 2 == 1 && m_p >= 3 && m_p <= 2 * COLS + 1);
        check("fb_rd_en", fb_rd_en, e_rd);
        if (e_rd) check("fb_addr", fb_addr, m_bank * BANK_SZ + m_row * COLS + m_p / 2);
        check("RGB", {R0, G0, B0, R1, G1, B1}, m_rgb);
        check("row_addr", {D, C, B, A}, m_abcd);
        check("front_bank", front_bank, m_bank);
        check("frame_done", frame_done, m_fd);
        check("swap_ack", swap_ack, m_ack);
    endtask

    task automatic step();
        bit         rd, r_rst, r_run, r_swap;
        logic [10:0] a;
        int         r_br;
        rd     = (fb_rd_en === 1'b1);
        a      = fb_addr;
        r_rst  = rst;
        r_run  = run;
        r_swap = swap_req;
        r_br   = brightness;
        @(posedge clk);
        #1;
        cyc++;
        fb_data = rd ? mem[a] : 6'($urandom);
        model_edge(r_rst, r_run, r_swap, r_br);
        compare();
        if (r_rst) sclk_rises = 0;
        else if (SCLK && !sclk_prev) sclk_rises++;
        sclk_prev = SCLK;
        if (LAT === 1'b1) begin
            check("sclk_rises_per_row", sclk_rises, COLS);
            sclk_rises = 0;
        end
        if (frame_done === 1'b1) begin
            fd_seen++;
            if (fd_last > 0) check("frame_period", cyc - fd_last, FRAME_PER);
            fd_last = cyc;
        end
        if (swap_ack === 1'b1) ack_seen++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int i = 0; i < 2048; i++) mem[i] = 6'($urandom);

        // Reset, then idle with run low.
        repeat (4) step();
        rst = 1'b0;
        step();
        check("fb_addr_reset", fb_addr, 0);
        repeat (20) step();

        // One full frame and a bit from bank 0.
        run = 1'b1;
        repeat (FRAME_PER + 10) step();

        // Swap requested mid-frame, with a brightness change that waits for the next frame.
        got = 0;
        for (int i = 0; i < FRAME_PER && !(m_active && m_row == 7); i++) step();
        check("reached_row7", m_row, 7);
        swap_req   = 1'b1;
        brightness = 8'd200;
        for (int i = 0; i < FRAME_PER + 10 && !got; i++) begin
            step();
            if (swap_ack === 1'b1) got = 1;
        end
        check("swap_ack_within_frame", got, 1);
        check("fb_addr_bank_on_ack", fb_addr[10], 1);
        swap_req = 1'b0;
        repeat (2 * ROW_PER) step();

        // Stop during row 5 shift while a swap is pending: no frame_done, no ack.
        for (int i = 0; i < FRAME_PER && !(m_active && m_row == 5 && m_p == 40); i++) step();
        check("reached_row5_shift", m_p, 40);
        run      = 1'b0;
        swap_req = 1'b1;
        fd_last  = 0;
        fd_seen  = 0;
        ack_seen = 0;
        repeat (2 * ROW_PER) step();
        check("no_frame_done_after_stop", fd_seen, 0);
        check("no_swap_ack_after_stop", ack_seen, 0);
        check("idle_oe_blank", OE, 1);
        swap_req = 1'b0;

        // Random swap requests and brightness over two continuous frames.
        run = 1'b1;
        for (int i = 0; i < 2 * FRAME_PER; i++) begin
            brightness = 8'($urandom);
            if (i % 1000 == 0) swap_req = 1'($urandom_range(0, 1));
            step();
        end
        swap_req = 1'b0;

        // Reset in the middle of a row's display.
        for (int i = 0; i < FRAME_PER && !(m_active && m_p == 200); i++) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        fd_last = 0;
        check("oe_after_reset", OE, 1);
        repeat (2 * ROW_PER) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
